load_store_buffer: RTL and testbench
====================================

// Module: load_store_buffer
// PURPOSE
// - Load/store reservation stations between issue and the address/memory unit: 2 load, 2 store entries.
// - Captures base/store-data operands from the CDB and computes effective address base + sext(imm).
// - Drives the load1/2 and store1/2 request ports of the address unit; frees entries on completion.
// - Loads complete on their CDB broadcast; stores complete when the address unit performs the write.
// PARAMETERS
// XLEN   32  data/address width
// TAG_W  4   reservation-station tag width; tag 0 = "operand ready, no producer"
// IMM_W  12  signed immediate width
// PORTS
// clk            in   1      clock
// reset          in   1      synchronous, active-high reset
// issue_valid    in   1      dispatch request this cycle
// issue_is_store in   1      1 = store, 0 = load
// issue_tag      in   TAG_W  load destination tag (ignored for stores)
// issue_qj       in   TAG_W  base producer tag (0 = issue_vj valid)
// issue_vj       in   XLEN   base value
// issue_qk       in   TAG_W  store-data producer tag (0 = issue_vk valid)
// issue_vk       in   XLEN   store-data value
// issue_imm      in   IMM_W  signed offset
// issue_ready    out  1      a free entry of the requested kind exists (combinational)
// cdb_valid      in   1      CDB broadcast valid
// cdb_tag        in   TAG_W  CDB tag
// cdb_data       in   XLEN   CDB value
// load1_valid/load2_valid    out 1      load entry presented to address unit
// load1_tag/load2_tag        out TAG_W  tag of that load
// load1_addr/load2_addr      out XLEN   effective address
// store1_valid/store2_valid  out 1      store entry presented
// store1_addr/store2_addr    out XLEN   effective address
// store1_data/store2_data    out XLEN   data to write
// BEHAVIOUR
// - Reset: all entries invalid; every output 0; age state cleared. Reset mid-operation drops all entries.
// - Dispatch accepted iff issue_valid && issue_ready; lowest-index free entry of the kind is allocated.
// - Entry states: FREE -> WAIT (any operand tag != 0) -> READY (all operands, addr registered) -> FREE.
// - CDB capture: waiting qj/qk == cdb_tag with cdb_valid -> value latched, tag cleared, same edge.
// - Dispatch-cycle bypass: issue_qj/qk == cdb_tag && cdb_valid -> capture cdb_data at allocation.
// - Address = vj + sign-extended imm, mod 2^XLEN; registered on the edge the base becomes known.
// - Latency: dispatch with ready operands -> request output valid the next cycle.
// - Ordering: each load records at dispatch a mask of occupied store entries (older stores).
//   Mask bit clears when that store frees. Load presented only when READY and mask == 0.
// - Stores presented strictly in program order: one store-age bit; only oldest store may assert valid.
// - Arbitration mirrors address unit priority: load1 > load2 > store1 > store2.
//   A store is written, and freed at the clock edge, iff its valid is high and no loadN_valid is high.
// - Load completion: freed when cdb_valid && cdb_tag == entry tag; loadN_valid drops the next cycle.
// - Simultaneous free and dispatch to same kind: issue_ready reflects start-of-cycle occupancy only.
// - Free entry's outputs: valid 0, tag/addr/data held at last value.
// - Tag 0 never used as a load destination (dispatcher guarantee; not checked).
// STRUCTURE
// - Shared pkg tomasulo_pkg: XLEN, TAG_W, IMM_W, NO_TAG = '0, typedef lsb_entry_t {valid, qj, qk, vj,
//   vk, imm, addr, tag, st_mask}.
// - One sub-module lsb_entry (operand capture + address add), instantiated 4x with IS_STORE parameter.
// - Top holds allocation, store-age bit, ordering masks and completion logic.
// TESTING
// - Load, qj=0 vj=0x100 imm=-4 -> next cycle load1_valid=1 addr=0xFC; CDB tag match -> load1_valid=0 next cycle.
// - Load qj=5; cdb_valid tag 5 data 0x40 two cycles later -> addr 0x40+imm valid the cycle after capture.
// - Store (ready) then load, no load eligible -> store1_valid=1 one cycle, freed; load presented only after store frees.
// - Two stores, second ready first -> store2 held until store1 written; then store2 valid, freed next cycle.
// - Dispatch with issue_qj == cdb_tag in same cycle -> bypass value used, entry READY next cycle.
// - Fill both load entries -> issue_ready=0 for loads, 1 for stores; reset mid-flight -> all valids 0 next cycle.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// ============================================================================
// Module      : tomasulo_pkg
// Description : Shared widths, entry-state encoding and the load/store entry
//               record used by the load/store reservation stations.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tomasulo_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int IMM_W = 12;
    localparam int N_LD  = 2;
    localparam int N_ST  = 2;

    localparam logic [TAG_W-1:0] NO_TAG = '0;

    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [IMM_W-1:0] imm;
        logic [XLEN-1:0]  addr;
        logic [TAG_W-1:0] tag;
        logic [N_ST-1:0]  st_mask;
    } lsb_entry_t;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsb_entry.sv
// ============================================================================
// Module      : lsb_entry
// Description : One load or store reservation entry: operand capture from the
//               CDB (including dispatch-cycle bypass) and effective address.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsb_entry
    import tomasulo_pkg::*;
#(
    parameter bit IS_STORE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    input  logic             i_free,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [TAG_W-1:0] i_qj,
    input  logic [XLEN-1:0]  i_vj,
    input  logic [TAG_W-1:0] i_qk,
    input  logic [XLEN-1:0]  i_vk,
    input  logic [IMM_W-1:0] i_imm,
    input  logic [N_ST-1:0]  i_st_mask,
    input  logic [N_ST-1:0]  i_st_clr,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [XLEN-1:0]  i_cdb_data,
    output logic             o_busy,
    output logic             o_ready,
    output logic             o_mask_zero,
    output logic [TAG_W-1:0] o_tag,
    output logic [XLEN-1:0]  o_addr,
    output logic [XLEN-1:0]  o_data
);

    lsb_entry_t       r_ent;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [TAG_W-1:0] w_qj;
    logic [TAG_W-1:0] w_qk;
    logic [XLEN-1:0]  w_vj;
    logic [XLEN-1:0]  w_vk;
    logic             w_cap_j;
    logic             w_cap_k;
    logic             w_ops_done;

    // Operands as they will be latched at allocation, after CDB bypass.
    always_comb begin
        w_qj = i_qj;
        w_vj = i_vj;
        if (i_cdb_valid && (i_qj != NO_TAG) && (i_qj == i_cdb_tag)) begin
            w_qj = NO_TAG;
            w_vj = i_cdb_data;
        end
        w_qk = NO_TAG;
        w_vk = '0;
        if (IS_STORE) begin
            w_qk = i_qk;
            w_vk = i_vk;
            if (i_cdb_valid && (i_qk != NO_TAG) && (i_qk == i_cdb_tag)) begin
                w_qk = NO_TAG;
                w_vk = i_cdb_data;
            end
        end
        w_cap_j    = r_ent.valid && (r_ent.qj != NO_TAG) && i_cdb_valid && (r_ent.qj == i_cdb_tag);
        w_cap_k    = r_ent.valid && (r_ent.qk != NO_TAG) && i_cdb_valid && (r_ent.qk == i_cdb_tag);
        w_ops_done = (w_cap_j || (r_ent.qj == NO_TAG)) && (w_cap_k || (r_ent.qk == NO_TAG));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FREE: begin
                if (i_alloc) begin
                    w_state_nxt = ((w_qj == NO_TAG) && (w_qk == NO_TAG)) ? ST_READY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_free) begin
                    w_state_nxt = ST_FREE;
                end else if (w_ops_done) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (i_free) begin
                    w_state_nxt = ST_FREE;
                end
            end
            default: w_state_nxt = ST_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FREE;
            r_ent   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_alloc) begin
                r_ent.valid   <= 1'b1;
                r_ent.qj      <= w_qj;
                r_ent.vj      <= w_vj;
                r_ent.qk      <= w_qk;
                r_ent.vk      <= w_vk;
                r_ent.imm     <= i_imm;
                r_ent.tag     <= IS_STORE ? NO_TAG : i_tag;
                r_ent.st_mask <= IS_STORE ? '0 : i_st_mask;
                if (w_qj == NO_TAG) begin
                    r_ent.addr <= w_vj + sext_imm(i_imm);
                end
            end else begin
                if (i_free) begin
                    r_ent.valid <= 1'b0;
                end
                if (w_cap_j) begin
                    r_ent.qj   <= NO_TAG;
                    r_ent.vj   <= i_cdb_data;
                    r_ent.addr <= i_cdb_data + sext_imm(r_ent.imm);
                end
                if (w_cap_k) begin
                    r_ent.qk <= NO_TAG;
                    r_ent.vk <= i_cdb_data;
                end
                r_ent.st_mask <= r_ent.st_mask & ~i_st_clr;
            end
        end
    end

    assign o_busy      = r_ent.valid;
    assign o_ready     = (r_state == ST_READY);
    assign o_mask_zero = (r_ent.st_mask == '0);
    assign o_tag       = r_ent.tag;
    assign o_addr      = r_ent.addr;
    assign o_data      = r_ent.vk;

endmodule

`default_nettype wire

// File: rtl/load_store_buffer.sv
// ============================================================================
// Module      : load_store_buffer
// Description : Two load and two store reservation entries feeding the address
//               unit, with allocation, store ordering and completion logic.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_buffer
    import tomasulo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_is_store,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [XLEN-1:0]  issue_vj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [XLEN-1:0]  issue_vk,
    input  logic [IMM_W-1:0] issue_imm,
    output logic             issue_ready,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             load1_valid,
    output logic [TAG_W-1:0] load1_tag,
    output logic [XLEN-1:0]  load1_addr,
    output logic             load2_valid,
    output logic [TAG_W-1:0] load2_tag,
    output logic [XLEN-1:0]  load2_addr,
    output logic             store1_valid,
    output logic [XLEN-1:0]  store1_addr,
    output logic [XLEN-1:0]  store1_data,
    output logic             store2_valid,
    output logic [XLEN-1:0]  store2_addr,
    output logic [XLEN-1:0]  store2_data
);

    logic [N_LD-1:0]  w_ld_busy, w_ld_ready, w_ld_mz, w_ld_valid, w_ld_alloc, w_ld_free;
    logic [N_ST-1:0]  w_st_busy, w_st_ready, w_st_mz, w_st_valid, w_st_alloc, w_st_free;
    logic [N_ST-1:0]  w_st_mask_new;
    logic [TAG_W-1:0] w_ld_tag  [N_LD];
    logic [XLEN-1:0]  w_ld_addr [N_LD];
    logic [XLEN-1:0]  w_ld_data [N_LD];
    logic [TAG_W-1:0] w_st_tag  [N_ST];
    logic [XLEN-1:0]  w_st_addr [N_ST];
    logic [XLEN-1:0]  w_st_data [N_ST];
    logic             w_accept;
    logic             r_st_old;

    assign issue_ready = issue_is_store ? ~(&w_st_busy) : ~(&w_ld_busy);
    assign w_accept    = issue_valid && issue_ready;

    assign w_ld_alloc[0] = w_accept && !issue_is_store && !w_ld_busy[0];
    assign w_ld_alloc[1] = w_accept && !issue_is_store && w_ld_busy[0] && !w_ld_busy[1];
    assign w_st_alloc[0] = w_accept && issue_is_store && !w_st_busy[0];
    assign w_st_alloc[1] = w_accept && issue_is_store && w_st_busy[0] && !w_st_busy[1];

    // Only the oldest store may present; any presented load outranks both stores.
    assign w_st_valid[0] = w_st_ready[0] && !r_st_old;
    assign w_st_valid[1] = w_st_ready[1] && r_st_old;
    assign w_ld_valid    = w_ld_ready & w_ld_mz;
    assign w_st_free     = (|w_ld_valid) ? '0 : w_st_valid;

    // A store leaving this edge is no longer older than a load arriving now.
    assign w_st_mask_new = w_st_busy & ~w_st_free;

    generate
        for (genvar i = 0; i < N_LD; i++) begin : g_load
            assign w_ld_free[i] = w_ld_busy[i] && cdb_valid && (cdb_tag == w_ld_tag[i]);

            lsb_entry #(.IS_STORE(1'b0)) u_entry (
                .clk         (clk),
                .rst         (reset),
                .i_alloc     (w_ld_alloc[i]),
                .i_free      (w_ld_free[i]),
                .i_tag       (issue_tag),
                .i_qj        (issue_qj),
                .i_vj        (issue_vj),
                .i_qk        (issue_qk),
                .i_vk        (issue_vk),
                .i_imm       (issue_imm),
                .i_st_mask   (w_st_mask_new),
                .i_st_clr    (w_st_free),
                .i_cdb_valid (cdb_valid),
                .i_cdb_tag   (cdb_tag),
                .i_cdb_data  (cdb_data),
                .o_busy      (w_ld_busy[i]),
                .o_ready     (w_ld_ready[i]),
                .o_mask_zero (w_ld_mz[i]),
                .o_tag       (w_ld_tag[i]),
                .o_addr      (w_ld_addr[i]),
                .o_data      (w_ld_data[i])
            );
        end

        for (genvar j = 0; j < N_ST; j++) begin : g_store
            lsb_entry #(.IS_STORE(1'b1)) u_entry (
                .clk         (clk),
                .rst         (reset),
                .i_alloc     (w_st_alloc[j]),
                .i_free      (w_st_free[j]),
                .i_tag       (issue_tag),
                .i_qj        (issue_qj),
                .i_vj        (issue_vj),
                .i_qk        (issue_qk),
                .i_vk        (issue_vk),
                .i_imm       (issue_imm),
                .i_st_mask   (w_st_mask_new),
                .i_st_clr    (w_st_free),
                .i_cdb_valid (cdb_valid),
                .i_cdb_tag   (cdb_tag),
                .i_cdb_data  (cdb_data),
                .o_busy      (w_st_busy[j]),
                .o_ready     (w_st_ready[j]),
                .o_mask_zero (w_st_mz[j]),
                .o_tag       (w_st_tag[j]),
                .o_addr      (w_st_addr[j]),
                .o_data      (w_st_data[j])
            );
        end
    endgenerate

    // Age bit names the older store; it moves to the survivor when the older frees.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_st_old <= 1'b0;
        end else if (w_st_free[0]) begin
            r_st_old <= 1'b1;
        end else if (w_st_free[1]) begin
            r_st_old <= 1'b0;
        end else if ((|w_st_alloc) && !(|w_st_busy)) begin
            r_st_old <= w_st_alloc[1];
        end
    end

    assign load1_valid  = w_ld_valid[0];
    assign load1_tag    = w_ld_tag[0];
    assign load1_addr   = w_ld_addr[0];
    assign load2_valid  = w_ld_valid[1];
    assign load2_tag    = w_ld_tag[1];
    assign load2_addr   = w_ld_addr[1];
    assign store1_valid = w_st_valid[0];
    assign store1_addr  = w_st_addr[0];
    assign store1_data  = w_st_data[0];
    assign store2_valid = w_st_valid[1];
    assign store2_addr  = w_st_addr[1];
    assign store2_data  = w_st_data[1];

endmodule

`default_nettype wire

// File: tb/tb_load_store_buffer.sv
// ============================================================================
// Module      : tb_load_store_buffer
// Description : Directed self-checking bench for load_store_buffer with an
//               in-order scoreboard of expected address-unit requests.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_is_store;
    logic [3:0]  issue_tag, issue_qj, issue_qk;
    logic [31:0] issue_vj, issue_vk;
    logic [11:0] issue_imm;
    logic        issue_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        load1_valid, load2_valid, store1_valid, store2_valid;
    logic [3:0]  load1_tag, load2_tag;
    logic [31:0] load1_addr, load2_addr, store1_addr, store2_addr, store1_data, store2_data;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] aux;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    load_store_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_is_store (issue_is_store),
        .issue_tag      (issue_tag),
        .issue_qj       (issue_qj),
        .issue_vj       (issue_vj),
        .issue_qk       (issue_qk),
        .issue_vk       (issue_vk),
        .issue_imm      (issue_imm),
        .issue_ready    (issue_ready),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .load1_valid    (load1_valid),
        .load1_tag      (load1_tag),
        .load1_addr     (load1_addr),
        .load2_valid    (load2_valid),
        .load2_tag      (load2_tag),
        .load2_addr     (load2_addr),
        .store1_valid   (store1_valid),
        .store1_addr    (store1_addr),
        .store1_data    (store1_data),
        .store2_valid   (store2_valid),
        .store2_addr    (store2_addr),
        .store2_data    (store2_data)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic port_valid(input int p);
        case (p)
            0:       return load1_valid;
            1:       return load2_valid;
            2:       return store1_valid;
            default: return store2_valid;
        endcase
    endfunction

    function automatic logic [31:0] port_addr(input int p);
        case (p)
            0:       return load1_addr;
            1:       return load2_addr;
            2:       return store1_addr;
            default: return store2_addr;
        endcase
    endfunction

    function automatic logic [31:0] port_aux(input int p);
        case (p)
            0:       return {28'd0, load1_tag};
            1:       return {28'd0, load2_tag};
            2:       return store1_data;
            default: return store2_data;
        endcase
    endfunction

    task automatic sb_push(input int p, input logic [31:0] addr, input logic [31:0] aux);
        exp_t e;
        e.port = p;
        e.addr = addr;
        e.aux  = aux;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the port to present, then check it against the oldest expectation.
    task automatic sb_wait(input int p);
        exp_t e;
        int   n = 0;
        while (!port_valid(p) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("port%0d_valid", p), {31'd0, port_valid(p)}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sb_port", p, e.port);
            chk($sformatf("port%0d_addr", p), port_addr(p), e.addr);
            chk($sformatf("port%0d_aux", p), port_aux(p), e.aux);
        end
    endtask

    task automatic dispatch(input logic st, input logic [3:0] tag, input logic [3:0] qj,
                            input logic [31:0] vj, input logic [3:0] qk, input logic [31:0] vk,
                            input logic [11:0] imm);
        issue_valid    = 1'b1;
        issue_is_store = st;
        issue_tag      = tag;
        issue_qj       = qj;
        issue_vj       = vj;
        issue_qk       = qk;
        issue_vk       = vk;
        issue_imm      = imm;
        @(negedge clk);
        issue_valid    = 1'b0;
        issue_is_store = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        @(negedge clk);
        cdb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0; issue_is_store = 1'b0; issue_tag = '0; issue_qj = '0;
        issue_qk = '0; issue_vj = '0; issue_vk = '0; issue_imm = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_load1_valid", {31'd0, load1_valid}, 32'd0);
        chk("rst_store2_valid", {31'd0, store2_valid}, 32'd0);
        chk("rst_load2_addr", load2_addr, 32'd0);
        chk("rst_store1_data", store1_data, 32'd0);
        reset = 1'b0;
        #1 chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);

        // Ready load: presented the next cycle, dropped after its CDB broadcast.
        sb_push(0, 32'h0000_00FC, 32'd3);
        dispatch(1'b0, 4'd3, 4'd0, 32'h100, 4'd0, 32'd0, 12'hFFC);
        chk("t1_latency", {31'd0, load1_valid}, 32'd1);
        sb_wait(0);
        cdb(4'd3, 32'h55);
        chk("t1_freed", {31'd0, load1_valid}, 32'd0);

        // Base from CDB two cycles after dispatch.
        dispatch(1'b0, 4'd6, 4'd5, 32'h0, 4'd0, 32'd0, 12'h008);
        chk("t2_wait0", {31'd0, load1_valid}, 32'd0);
        @(negedge clk);
        chk("t2_wait1", {31'd0, load1_valid}, 32'd0);
        sb_push(0, 32'h48, 32'd6);
        cdb(4'd5, 32'h40);
        chk("t2_after_capture", {31'd0, load1_valid}, 32'd1);
        sb_wait(0);
        cdb(4'd6, 32'h0);

        // Load younger than a waiting store stays hidden until the store writes.
        sb_push(2, 32'h210, 32'hDEAD);
        sb_push(0, 32'h300, 32'd7);
        dispatch(1'b1, 4'd0, 4'd0, 32'h200, 4'd9, 32'd0, 12'h010);
        dispatch(1'b0, 4'd7, 4'd0, 32'h300, 4'd0, 32'd0, 12'h000);
        chk("t3_load_blocked", {31'd0, load1_valid}, 32'd0);
        chk("t3_store_waiting", {31'd0, store1_valid}, 32'd0);
        cdb(4'd9, 32'hDEAD);
        chk("t3_load_still_blocked", {31'd0, load1_valid}, 32'd0);
        sb_wait(2);
        @(negedge clk);
        chk("t3_store_freed", {31'd0, store1_valid}, 32'd0);
        sb_wait(0);
        cdb(4'd7, 32'h0);

        // A presented load keeps a ready store from being written.
        sb_push(0, 32'h400, 32'd2);
        sb_push(2, 32'h800, 32'h77);
        dispatch(1'b0, 4'd2, 4'd0, 32'h400, 4'd0, 32'd0, 12'h000);
        sb_wait(0);
        dispatch(1'b1, 4'd0, 4'd0, 32'h800, 4'd0, 32'h77, 12'h000);
        sb_wait(2);
        @(negedge clk);
        chk("t3b_store_held", {31'd0, store1_valid}, 32'd1);
        cdb(4'd2, 32'h0);
        chk("t3b_load_gone", {31'd0, load1_valid}, 32'd0);
        chk("t3b_store_still", {31'd0, store1_valid}, 32'd1);
        @(negedge clk);
        chk("t3b_store_written", {31'd0, store1_valid}, 32'd0);

        // Second store ready first must wait for the older one.
        sb_push(2, 32'h500, 32'hAAAA);
        sb_push(3, 32'h600, 32'hB);
        dispatch(1'b1, 4'd0, 4'd0, 32'h500, 4'hA, 32'd0, 12'h000);
        dispatch(1'b1, 4'd0, 4'd0, 32'h600, 4'd0, 32'hB, 12'h000);
        chk("t4_st2_held0", {31'd0, store2_valid}, 32'd0);
        @(negedge clk);
        chk("t4_st2_held1", {31'd0, store2_valid}, 32'd0);
        cdb(4'hA, 32'hAAAA);
        chk("t4_st2_held2", {31'd0, store2_valid}, 32'd0);
        sb_wait(2);
        @(negedge clk);
        chk("t4_st1_freed", {31'd0, store1_valid}, 32'd0);
        sb_wait(3);
        @(negedge clk);
        chk("t4_st2_freed", {31'd0, store2_valid}, 32'd0);

        // Dispatch-cycle bypass of the base operand.
        sb_push(0, 32'h17FF, 32'd4);
        cdb_valid = 1'b1; cdb_tag = 4'd8; cdb_data = 32'h1000;
        dispatch(1'b0, 4'd4, 4'd8, 32'hDEAD, 4'd0, 32'd0, 12'h7FF);
        cdb_valid = 1'b0;
        chk("t5_bypass_ready", {31'd0, load1_valid}, 32'd1);
        sb_wait(0);
        cdb(4'd4, 32'h0);

        // Fill both loads, check per-kind ready, then reset mid-flight.
        sb_push(0, 32'h10, 32'd1);
        sb_push(1, 32'h1F, 32'd2);
        dispatch(1'b0, 4'd1, 4'd0, 32'h10, 4'd0, 32'd0, 12'h000);
        dispatch(1'b0, 4'd2, 4'd0, 32'h20, 4'd0, 32'd0, 12'hFFF);
        sb_wait(0);
        sb_wait(1);
        issue_is_store = 1'b0;
        #1 chk("t6_ready_load_full", {31'd0, issue_ready}, 32'd0);
        issue_is_store = 1'b1;
        #1 chk("t6_ready_store", {31'd0, issue_ready}, 32'd1);
        issue_is_store = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_load1", {31'd0, load1_valid}, 32'd0);
        chk("t6_rst_load2", {31'd0, load2_valid}, 32'd0);
        chk("t6_rst_load2_addr", load2_addr, 32'd0);
        chk("t6_rst_ready", {31'd0, issue_ready}, 32'd1);
        reset = 1'b0;

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
